// File: rtl/seq_pkg.sv
// Constants shared by the serializer and the bit-serial sequence detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_pkg;

  // Default parallel word width fed to the serializer.
  localparam int   SER_DATA_W_DEF = 8;

  // Serial line level while no data bit is present. The detector uses the
  // same value, so an idle line never looks like the start of a match.
  localparam logic SER_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/word_serializer.sv
// Purpose: parallel-to-serial front end for the bit-serial sequence detector.
// Latency: word accepted at edge N into an empty shifter -> first bit valid after edge N+1.
// Backpressure: in_ready drops while the one-word holding register is full; ser_en=0 freezes the serial side.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active-high
//   in_data    parallel word (DATA_W bits)
//   in_valid   in_data is valid
//   in_ready   block can accept a word
//   ser_en     bit-rate enable; 0 freezes the serial output
//   ser_bit    serial data (detector x)
//   ser_valid  ser_bit carries a data bit
//   last_bit   ser_bit is the final bit of the current word
//   busy       word held or being shifted
module word_serializer
  import seq_pkg::*;
#(
  parameter int   DATA_W     = SER_DATA_W_DEF,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ser_en,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              last_bit,
  output logic              busy
);

  localparam int              CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic [DATA_W-1:0] sh_data;
  logic              sh_valid;
  logic [CNT_W-1:0]  bit_cnt;

  logic accept;
  logic consume;
  logic cnt_zero;
  logic load_sh;
  logic end_bit;

  assign accept   = in_valid & in_ready;
  assign consume  = ser_en & sh_valid;
  assign cnt_zero = (bit_cnt == '0);

  // Hold feeds the shifter either when the shifter is empty (independent of
  // ser_en) or when the final bit of the current word is being consumed, which
  // is what keeps consecutive words gap-free. accept and load_sh are mutually
  // exclusive: accept needs hold empty, load_sh needs it full.
  assign load_sh  = hold_full & (~sh_valid | (consume & cnt_zero));

  assign end_bit  = MSB_FIRST ? sh_data[DATA_W-1] : sh_data[0];

  // All outputs decode registered state; rst gates in_ready directly so the
  // block refuses words for the whole reset pulse.
  assign in_ready  = ~hold_full & ~rst;
  assign ser_valid = sh_valid;
  assign ser_bit   = sh_valid ? end_bit : IDLE_LEVEL;
  assign last_bit  = sh_valid & cnt_zero;
  assign busy      = sh_valid | hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      sh_data   <= '0;
      sh_valid  <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      if (accept) begin
        hold_data <= in_data;
      end

      if (accept) begin
        hold_full <= 1'b1;
      end else if (load_sh) begin
        hold_full <= 1'b0;
      end

      if (load_sh) begin
        sh_data  <= hold_data;
        sh_valid <= 1'b1;
        bit_cnt  <= CNT_MAX;
      end else if (consume) begin
        if (!cnt_zero) begin
          // Move the next bit toward the output end.
          sh_data <= MSB_FIRST ? {sh_data[DATA_W-2:0], 1'b0}
                               : {1'b0, sh_data[DATA_W-1:1]};
          bit_cnt <= bit_cnt - CNT_W'(1);
        end else begin
          sh_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer: MSB-first and LSB-first instances checked
// against a bit-level scoreboard filled on accept and drained on consume.
// Ports of both instances are fully connected; rst and ser_en are shared.
module tb_word_serializer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_en;

  logic [7:0] in_data_m, in_data_l;
  logic       in_valid_m, in_valid_l;
  logic       in_ready_m, in_ready_l;
  logic       ser_bit_m, ser_bit_l;
  logic       ser_valid_m, ser_valid_l;
  logic       last_bit_m, last_bit_l;
  logic       busy_m, busy_l;

  always #5 clk = ~clk;

  word_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data_m), .in_valid(in_valid_m),
    .in_ready(in_ready_m), .ser_en(ser_en), .ser_bit(ser_bit_m),
    .ser_valid(ser_valid_m), .last_bit(last_bit_m), .busy(busy_m)
  );

  word_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .ser_en(ser_en), .ser_bit(ser_bit_l),
    .ser_valid(ser_valid_l), .last_bit(last_bit_l), .busy(busy_l)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {expected bit, expected last flag}.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];

  int   run_m      = 0;
  int   last_run_m = 0;
  logic prev_en      = 1'b1;
  logic prev_valid_m = 1'b0;
  logic prev_bit_m   = 1'b0;
  logic prev_last_m  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input bit lsb, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      logic b;
      b = lsb ? w[i] : w[7-i];
      if (lsb) q_l.push_back({b, (i == 7)});
      else     q_m.push_back({b, (i == 7)});
    end
  endtask

  // Called at a falling edge: check outputs, update scoreboard for the coming
  // rising edge, then advance to the next falling edge.
  task automatic tick();
    logic [1:0] e;
    if (prev_valid_m && !prev_en) begin
      check("stall_valid", ser_valid_m, 1);
      check("stall_bit",   ser_bit_m,   prev_bit_m);
      check("stall_last",  last_bit_m,  prev_last_m);
    end
    if (in_valid_m && in_ready_m) push_word(1'b0, in_data_m);
    if (in_valid_l && in_ready_l) push_word(1'b1, in_data_l);

    if (!ser_valid_m) check("idle_bit_m", ser_bit_m, 1);
    if (!ser_valid_l) check("idle_bit_l", ser_bit_l, 1);

    if (ser_valid_m && ser_en) begin
      if (q_m.size() == 0) check("extra_bit_m", ser_valid_m, 0);
      else begin
        e = q_m.pop_front();
        check("bit_m",  ser_bit_m,  e[1]);
        check("last_m", last_bit_m, e[0]);
      end
    end
    if (ser_valid_l && ser_en) begin
      if (q_l.size() == 0) check("extra_bit_l", ser_valid_l, 0);
      else begin
        e = q_l.pop_front();
        check("bit_l",  ser_bit_l,  e[1]);
        check("last_l", last_bit_l, e[0]);
      end
    end

    if (ser_valid_m) run_m++;
    else if (run_m > 0) begin
      last_run_m = run_m;
      run_m      = 0;
    end
    prev_en      = ser_en;
    prev_valid_m = ser_valid_m;
    prev_bit_m   = ser_bit_m;
    prev_last_m  = last_bit_m;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input bit lsb, input logic [7:0] w);
    bit done;
    done = 1'b0;
    if (lsb) begin in_valid_l = 1'b1; in_data_l = w; end
    else     begin in_valid_m = 1'b1; in_data_m = w; end
    for (int n = 0; n < 50; n++) begin
      if (lsb ? (in_valid_l & in_ready_l) : (in_valid_m & in_ready_m)) done = 1'b1;
      tick();
      if (done) break;
    end
    if (!done) check("accept_timeout", lsb ? in_ready_l : in_ready_m, 1);
    if (lsb) in_valid_l = 1'b0;
    else     in_valid_m = 1'b0;
  endtask

  // mode 0: ser_en always 1; mode 1: ser_en pattern 1,0,0 repeating.
  task automatic drain(input int mode);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!busy_m && !busy_l && q_m.size() == 0 && q_l.size() == 0) begin
        done = 1'b1;
        break;
      end
      ser_en = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      tick();
    end
    if (!done) check("drain_timeout", busy_m | busy_l, 0);
    ser_en = 1'b1;
    tick();
  endtask

  // Assert reset away from a clock edge, check outputs respond at once,
  // release at the next falling edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_valid"}, ser_valid_m, 0);
    check({tag, "_bit"},   ser_bit_m,   1);
    check({tag, "_rdy"},   in_ready_m,  0);
    check({tag, "_last"},  last_bit_m,  0);
    check({tag, "_busy"},  busy_m,      0);
    q_m.delete();
    q_l.delete();
    run_m        = 0;
    prev_valid_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_rel_rdy"},  in_ready_m, 1);
    check({tag, "_rel_busy"}, busy_m,     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    ser_en     = 1'b1;
    in_data_m  = '0;
    in_data_l  = '0;
    in_valid_m = 1'b0;
    in_valid_l = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("por_valid", ser_valid_m, 0);
    check("por_bit",   ser_bit_m,   1);
    check("por_rdy",   in_ready_m,  0);
    check("por_busy",  busy_m,      0);
    check("por_last",  last_bit_m,  0);
    rst = 1'b0;
    #1;
    check("por_rel_rdy", in_ready_m, 1);
    @(negedge clk);

    // Reset asserted mid-stream.
    send_word(1'b0, 8'h5A);
    tick();
    tick();
    pulse_reset("rst1");

    // Single word, first-bit latency and trailing idle.
    send_word(1'b0, 8'h66);
    check("t2_lat0_valid", ser_valid_m, 0);
    tick();
    check("t2_lat1_valid", ser_valid_m, 1);
    drain(0);
    check("t2_run",      last_run_m, 8);
    check("t2_end_valid", ser_valid_m, 0);
    check("t2_end_bit",   ser_bit_m,   1);

    // Back-to-back words stream without a gap.
    send_word(1'b0, 8'hA5);
    check("t3_rdy_after_a5", in_ready_m, 0);
    send_word(1'b0, 8'h3C);
    check("t3_rdy_after_3c", in_ready_m, 0);
    check("t3_busy", busy_m, 1);
    drain(0);
    check("t3_run", last_run_m, 16);

    // Stalled bit-rate enable.
    send_word(1'b0, 8'hC3);
    drain(1);
    check("t4_left", q_m.size(), 0);

    // LSB-first instance.
    send_word(1'b1, 8'h01);
    drain(0);
    check("t5_left", q_l.size(), 0);

    // Reset with a partial word shifting and another held.
    send_word(1'b0, 8'hF0);
    send_word(1'b0, 8'h0F);
    tick();
    tick();
    check("t6_busy_pre", busy_m, 1);
    check("t6_valid_pre", ser_valid_m, 1);
    pulse_reset("rst6");
    send_word(1'b0, 8'h06);
    drain(0);
    check("t6_run", last_run_m, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
